// File: rtl/phys_reg_wb_arbiter_pkg.sv
// phys_reg_wb_arbiter_pkg: shared writeback widths and result entry type
package phys_reg_wb_arbiter_pkg;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/phys_reg_wb_arbiter_wb_fifo.sv
// wb_fifo: DEPTH-entry result queue with two ordered push ports and one pop port
module wb_fifo
  import phys_reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push0,
  input  wb_entry_t                d0,
  input  logic                     push1,
  input  wb_entry_t                d1,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign head = mem[rp];
  assign empty = count == '0;
  // push1 is only ever asserted together with push0, so it lands one slot behind
  always_ff @(posedge clk) begin
    if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push0) mem[wp] <= d0;
      if (push1) mem[wp + PW'(1)] <= d1;
      wp <= wp + PW'(push0) + PW'(push1);
      rp <= rp + PW'(pop);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end
endmodule

// File: rtl/phys_reg_wb_arbiter.sv
// phys_reg_wb_arbiter: queues ALU/MEM results and drains one per unstalled cycle to the regfile
// Optional same-cycle bypass on an empty queue when WB_BYPASS_EN is defined.
module phys_reg_wb_arbiter
  import phys_reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   mem_valid,
  input  logic [TAG_W-1:0]       mem_tag,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  input  logic                   alu_valid,
  input  logic [TAG_W-1:0]       alu_tag,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  output logic [TAG_W-1:0]       reg_to_update,
  output logic [DATA_W-1:0]      new_value,
  output logic                   update,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  wb_entry_t mem_e, alu_e, head, d0, out_e;
  logic [CW-1:0] free;
  logic empty, mem_acc, alu_acc, byp, show, pop, push0, push1;
  assign mem_e = '{tag: mem_tag, data: mem_data};
  assign alu_e = '{tag: alu_tag, data: alu_data};
  // free space is the start-of-cycle value; a same-cycle pop earns no credit
  assign free = CW'(DEPTH) - count;
  assign mem_ready = !reset && !flush && free != '0;
  assign alu_ready = !reset && !flush && free >= (mem_valid ? CW'(2) : CW'(1));
  assign mem_acc = mem_valid && mem_ready;
  assign alu_acc = alu_valid && alu_ready;
`ifdef WB_BYPASS_EN
  assign byp = empty && !stall && !flush && (mem_acc || alu_acc);
`else
  assign byp = 1'b0;
`endif
  // a bypassed MEM result leaves the ALU result as the only one to queue
  assign push0 = byp ? mem_acc && alu_acc : mem_acc || alu_acc;
  assign push1 = !byp && mem_acc && alu_acc;
  assign d0 = (mem_acc && !byp) ? mem_e : alu_e;
  assign show = !reset && !flush && !empty;
  assign pop = show && !stall;
  assign update = byp || pop;
  assign out_e = byp ? (mem_acc ? mem_e : alu_e) : (show ? head : '0);
  assign reg_to_update = out_e.tag;
  assign new_value = out_e.data;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .clear(reset || flush),
    .push0(push0),
    .d0(d0),
    .push1(push1),
    .d1(alu_e),
    .pop(pop),
    .head(head),
    .empty(empty),
    .count(count)
  );
endmodule
